// File: rtl/noise_sample_down.sv
// Decimating I/Q integrator feeding noise_calc: sums N samples per block, then
// rounds, shifts and saturates each block sum to a symmetric 6-bit result.
module noise_sample_down #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       data_en,
  input  logic signed [IN_WIDTH-1:0] i_data,
  input  logic signed [IN_WIDTH-1:0] q_data,
  input  logic [7:0]                 down_ratio,
  input  logic [2:0]                 round_shift,
  input  logic                       clear_stat,
  output logic                       data_down_en,
  output logic signed [5:0]          i_data_down,
  output logic signed [5:0]          q_data_down,
  output logic                       shift_code,
  output logic [15:0]                sat_count
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
  localparam int unsigned OUT_WIDTH = 6;
  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'(31);
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = -SAT_MAX;

  logic [7:0]                  cnt;
  logic signed [ACC_WIDTH-1:0] acc_i;
  logic signed [ACC_WIDTH-1:0] acc_q;

  logic                        accept;
  logic                        block_end;
  logic [7:0]                  last_idx;
  logic signed [SUM_WIDTH-1:0] sum_i;
  logic signed [SUM_WIDTH-1:0] sum_q;
  logic [OUT_WIDTH:0]          res_i;
  logic [OUT_WIDTH:0]          res_q;
  logic                        any_sat;

  // Round-half-up arithmetic shift, then clamp to [-31, +31]; MSB flags saturation.
  function automatic logic [OUT_WIDTH:0] round_sat(
    input logic signed [SUM_WIDTH-1:0] sum,
    input logic [2:0]                  s
  );
    logic signed [SUM_WIDTH-1:0] bias;
    logic signed [SUM_WIDTH-1:0] r;
    bias = '0;
    if (s != 3'd0) begin
      bias = SUM_WIDTH'(1) <<< (s - 3'd1);
    end
    r = (sum + bias) >>> s;
    if (r > SAT_MAX) begin
      round_sat = {1'b1, 6'sd31};
    end else if (r < SAT_MIN) begin
      round_sat = {1'b1, -6'sd31};
    end else begin
      round_sat = {1'b0, r[OUT_WIDTH-1:0]};
    end
  endfunction

  // down_ratio of 0 wraps to 255, i.e. a 256-sample block.
  always_comb begin
    last_idx  = down_ratio - 8'd1;
    accept    = enable & data_en;
    block_end = accept & (cnt >= last_idx);
    sum_i     = SUM_WIDTH'(acc_i) + SUM_WIDTH'(i_data);
    sum_q     = SUM_WIDTH'(acc_q) + SUM_WIDTH'(q_data);
    res_i     = round_sat(sum_i, round_shift);
    res_q     = round_sat(sum_q, round_shift);
    any_sat   = res_i[OUT_WIDTH] | res_q[OUT_WIDTH];
  end

  // Block integration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      acc_i        <= '0;
      acc_q        <= '0;
      data_down_en <= 1'b0;
      shift_code   <= 1'b0;
      i_data_down  <= '0;
      q_data_down  <= '0;
    end else begin
      data_down_en <= block_end;
      shift_code   <= block_end;
      if (!enable) begin
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else if (block_end) begin
        cnt         <= '0;
        acc_i       <= '0;
        acc_q       <= '0;
        i_data_down <= res_i[OUT_WIDTH-1:0];
        q_data_down <= res_q[OUT_WIDTH-1:0];
      end else if (accept) begin
        cnt   <= cnt + 8'd1;
        acc_i <= acc_i + ACC_WIDTH'(i_data);
        acc_q <= acc_q + ACC_WIDTH'(q_data);
      end
    end
  end

  // Saturation statistics; clear wins over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clear_stat) begin
      sat_count <= '0;
    end else if (block_end && any_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_noise_sample_down.sv
// Scoreboard bench for noise_sample_down: integer-arithmetic reference model,
// directed cases followed by randomized traffic.
module tb_noise_sample_down;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned ACC_W = 12;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   enable = 1'b0;
  logic                   data_en = 1'b0;
  logic signed [IN_W-1:0] i_data = '0;
  logic signed [IN_W-1:0] q_data = '0;
  logic [7:0]             down_ratio = 8'd4;
  logic [2:0]             round_shift = 3'd0;
  logic                   clear_stat = 1'b0;
  logic                   data_down_en;
  logic signed [5:0]      i_data_down;
  logic signed [5:0]      q_data_down;
  logic                   shift_code;
  logic [15:0]            sat_count;

  noise_sample_down #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_en(data_en),
    .i_data(i_data), .q_data(q_data), .down_ratio(down_ratio),
    .round_shift(round_shift), .clear_stat(clear_stat),
    .data_down_en(data_down_en), .i_data_down(i_data_down),
    .q_data_down(q_data_down), .shift_code(shift_code), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int i; int q; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference state: samples in current block, running sums, visible outputs.
  int m_cnt = 0, m_sum_i = 0, m_sum_q = 0;
  int m_hold_i = 0, m_hold_q = 0, m_sat = 0;

  function automatic int ref_round(input int sum, input int s);
    int d, v;
    if (s == 0) return sum;
    d = 1 << s;
    v = sum + d / 2;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int clamp31(input int v);
    if (v > 31) return 31;
    if (v < -31) return -31;
    return v;
  endfunction

  // Applies the block rules to the inputs sampled at the edge just taken.
  task automatic model_edge();
    int n, ri, rq, new_sat;
    exp_t e;
    n = (down_ratio == 8'd0) ? 256 : int'(down_ratio);
    new_sat = m_sat;
    if (!enable) begin
      m_cnt = 0; m_sum_i = 0; m_sum_q = 0;
    end else if (data_en) begin
      m_sum_i += int'(i_data);
      m_sum_q += int'(q_data);
      m_cnt++;
      if (m_cnt >= n) begin
        ri = ref_round(m_sum_i, int'(round_shift));
        rq = ref_round(m_sum_q, int'(round_shift));
        if ((clamp31(ri) != ri || clamp31(rq) != rq) && new_sat < 65535) new_sat++;
        e.cyc = cyc + 1; e.i = clamp31(ri); e.q = clamp31(rq);
        exp_q.push_back(e);
        m_hold_i = e.i; m_hold_q = e.q;
        m_cnt = 0; m_sum_i = 0; m_sum_q = 0;
      end
    end
    if (clear_stat) new_sat = 0;
    m_sat = new_sat;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cnt = 0; m_sum_i = 0; m_sum_q = 0;
    m_hold_i = 0; m_hold_q = 0; m_sat = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic feed(input int n, input int iv, input int qv, input int gap);
    for (int k = 0; k < n; k++) begin
      enable = 1'b1; data_en = 1'b1;
      i_data = IN_W'(iv); q_data = IN_W'(qv);
      tick();
      data_en = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    data_en = 1'b0;
  endtask

  // Monitor: pulses are popped from the scoreboard; held values checked every cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    checks++;
    if (shift_code !== data_down_en) begin
      errors++;
      $display("FAIL pulse_align cyc=%0d shift_code=%b data_down_en=%b", cyc, shift_code, data_down_en);
    end
    if (data_down_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got i=%0d q=%0d", cyc, i_data_down, q_data_down);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || int'(i_data_down) != e.i || int'(q_data_down) != e.q) begin
          errors++;
          $display("FAIL block_out cyc=%0d got i=%0d q=%0d, expected cyc=%0d i=%0d q=%0d",
                   cyc, i_data_down, q_data_down, e.cyc, e.i, e.q);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL missed_pulse cyc=%0d expected i=%0d q=%0d", cyc, e.i, e.q);
    end
    checks++;
    if (int'(i_data_down) != m_hold_i || int'(q_data_down) != m_hold_q || int'(sat_count) != m_sat) begin
      errors++;
      $display("FAIL held_state cyc=%0d got i=%0d q=%0d sat=%0d, expected i=%0d q=%0d sat=%0d",
               cyc, i_data_down, q_data_down, sat_count, m_hold_i, m_hold_q, m_sat);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // N=4, s=0: +3/-2 -> 12/-8
    down_ratio = 8'd4; round_shift = 3'd0;
    feed(4, 3, -2, 0);
    tick(); tick();

    // N=16, s=2: 112 -> 28, -16 -> -4, contiguous then gapped
    down_ratio = 8'd16; round_shift = 3'd2;
    feed(16, 7, 0, 0);
    feed(16, -1, 0, 0);
    feed(16, 7, 0, 2);
    feed(16, -1, 0, 2);
    tick();

    // N=256, s=0: saturation both signs, then clear coincident with a saturating block
    down_ratio = 8'd0; round_shift = 3'd0;
    feed(256, 7, 0, 0);
    feed(256, 0, -8, 0);
    feed(255, 7, 0, 0);
    clear_stat = 1'b1;
    feed(1, 7, 0, 0);
    clear_stat = 1'b0;
    tick(); tick();

    // N=2, s=1 rounding: 3 -> 2, -3 -> -1, 1 -> 1
    down_ratio = 8'd2; round_shift = 3'd1;
    feed(1, 1, 2, 0);  feed(1, 2, 1, 0);
    feed(1, -1, -2, 0); feed(1, -2, -1, 0);
    feed(1, 0, 1, 0);  feed(1, 1, 0, 0);
    tick();

    // N shrinks mid-block: 6th sample ends the block
    down_ratio = 8'd8; round_shift = 3'd0;
    feed(5, 1, -1, 0);
    down_ratio = 8'd2;
    feed(1, 2, -2, 0);
    feed(2, 3, 1, 0);
    tick();

    // enable dropped mid-block
    down_ratio = 8'd8;
    feed(3, 5, 5, 0);
    enable = 1'b0; data_en = 1'b1; tick(); tick();
    data_en = 1'b0;
    feed(8, -3, 2, 0);
    tick();

    // reset mid-block
    feed(5, 4, -4, 0);
    do_reset();
    feed(8, 2, 1, 0);
    tick(); tick();

    // randomized traffic
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 5))
          0: down_ratio = 8'd1;
          1: down_ratio = 8'd2;
          2: down_ratio = 8'd3;
          3: down_ratio = 8'd8;
          4: down_ratio = 8'd16;
          default: down_ratio = 8'(40 + $urandom_range(0, 215));
        endcase
      end
      if (exp_q.size() == 0 && $urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        enable      = ($urandom_range(0, 24) != 0);
        data_en     = ($urandom_range(0, 2) != 0);
        i_data      = IN_W'($urandom);
        q_data      = IN_W'($urandom);
        round_shift = 3'($urandom);
        clear_stat  = ($urandom_range(0, 149) == 0);
        tick();
      end
    end
    enable = 1'b1; data_en = 1'b0; clear_stat = 1'b0;
    tick(); tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
